// File: rtl/mul32_pkg.sv
// mul32_pkg: shared definitions for the 32x32 multiplier datapath.
// Holds the default column geometry, the wide accumulator width and
// the state type of the column accumulator.
package mul32_pkg;

    localparam int DEF_NUM_COLS  = 7;
    localparam int DEF_COL_SHIFT = 8;
    localparam int DEF_SUM_W     = 16;
    localparam int DEF_CARRY_W   = 8;
    localparam int DEF_PROD_W    = 64;

    // Accumulator is wide enough to hold the product plus any column overflow.
    localparam int ACC_W = DEF_PROD_W + DEF_SUM_W + DEF_CARRY_W;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/mul32_col_shift.sv
// mul32_col_shift: combinational column weighting.
// Ports:
//   col   - column index (byte weight)
//   sum   - column sum
//   carry - column carry, weight 2^SUM_W relative to sum
//   term  - {carry, sum} zero-extended to TERM_W and shifted by COL_SHIFT*col
module mul32_col_shift
    import mul32_pkg::*;
#(
    parameter int COL_SHIFT = DEF_COL_SHIFT,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int CARRY_W   = DEF_CARRY_W,
    parameter int TERM_W    = ACC_W,
    parameter int COL_W     = 3
) (
    input  logic [COL_W-1:0]   col,
    input  logic [SUM_W-1:0]   sum,
    input  logic [CARRY_W-1:0] carry,
    output logic [TERM_W-1:0]  term
);

    always_comb begin
        term = TERM_W'({carry, sum}) << (COL_SHIFT * int'(col));
    end

endmodule

// File: rtl/mul32_column_accum.sv
// mul32_column_accum: sink stage of the 32x32 multiplier.
// Accepts one column (sum + carry) per beat in order 0..NUM_COLS-1,
// weights each by its byte position, accumulates into a wide register and
// presents the finished product over a valid/ready handshake.
// Ports:
//   clk, rstn              - clock (rising edge), async active-low reset
//   clear                  - synchronous abort of the current product
//   in_valid/in_ready      - column beat handshake, in_sum/in_carry payload
//   out_valid/out_ready    - product handshake, out_product/out_ovf payload
//   busy                   - a product is in progress or awaiting delivery
module mul32_column_accum
    import mul32_pkg::*;
#(
    parameter int NUM_COLS  = DEF_NUM_COLS,
    parameter int COL_SHIFT = DEF_COL_SHIFT,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int CARRY_W   = DEF_CARRY_W,
    parameter int PROD_W    = DEF_PROD_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SUM_W-1:0]   in_sum,
    input  logic [CARRY_W-1:0] in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PROD_W-1:0]  out_product,
    output logic               out_ovf,
    output logic               busy
);

    localparam int TERM_W = PROD_W + SUM_W + CARRY_W;
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    state_t              state;
    logic [COL_W-1:0]    col;
    logic [TERM_W-1:0]   acc;
    logic [TERM_W-1:0]   term;
    logic [TERM_W-1:0]   acc_sum;
    logic [PROD_W-1:0]   product;
    logic                ovf;
    logic                last_col;

    mul32_col_shift #(
        .COL_SHIFT (COL_SHIFT),
        .SUM_W     (SUM_W),
        .CARRY_W   (CARRY_W),
        .TERM_W    (TERM_W),
        .COL_W     (COL_W)
    ) u_col_shift (
        .col   (col),
        .sum   (in_sum),
        .carry (in_carry),
        .term  (term)
    );

    always_comb begin
        acc_sum  = acc + term;
        last_col = (col == COL_W'(NUM_COLS - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ACCUM;
            col     <= '0;
            acc     <= '0;
            product <= '0;
            ovf     <= '0;
        end else if (clear) begin
            state   <= ACCUM;
            col     <= '0;
            acc     <= '0;
            product <= '0;
            ovf     <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_sum;
                        col <= col + 1'b1;
                        if (last_col) begin
                            state   <= DONE;
                            product <= acc_sum[PROD_W-1:0];
                            ovf     <= |acc_sum[TERM_W-1:PROD_W];
                        end
                    end
                end
                DONE: begin
                    // product/ovf are cleared on delivery so they read zero
                    // whenever out_valid is low.
                    if (out_ready) begin
                        state   <= ACCUM;
                        col     <= '0;
                        acc     <= '0;
                        product <= '0;
                        ovf     <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state == ACCUM);
        out_valid   = (state == DONE);
        out_product = product;
        out_ovf     = ovf;
        busy        = (state == DONE) || (col != '0);
    end

endmodule
